// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - load/clear/count-up/count-down sequencer driving a bank of JK flops
// Optional saturating count (stop at all-ones / zero) enabled by defining JK_CTRL_SAT_EN.
module jk_bank_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] steps,
  input  logic [WIDTH-1:0]  q_fb,
  output logic [WIDTH-1:0]  j_out,
  output logic [WIDTH-1:0]  k_out,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] M_LOAD  = 2'b00;
  localparam logic [1:0] M_UP    = 2'b01;
  localparam logic [1:0] M_DOWN  = 2'b10;
  localparam logic [1:0] M_CLEAR = 2'b11;

  logic [1:0]        state;
  logic [1:0]        mode_r;
  logic [WIDTH-1:0]  val_r;
  logic [STEP_W-1:0] cnt_r;
  logic [WIDTH-1:0]  t_up;
  logic [WIDTH-1:0]  t_dn;
  logic [WIDTH-1:0]  low_mask;
  logic              sat_hit;

  // Toggle enables of a synchronous binary counter: bit i flips when all lower bits
  // are 1 (up) or all lower bits are 0 (down).
  always_comb begin
    t_up     = '0;
    t_dn     = '0;
    low_mask = '0;
    t_up[0]  = 1'b1;
    t_dn[0]  = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      low_mask = (WIDTH'(1) << i) - WIDTH'(1);
      t_up[i]  = &(q_fb | ~low_mask);
      t_dn[i]  = ~|(q_fb & low_mask);
    end
  end

`ifdef JK_CTRL_SAT_EN
  assign sat_hit = (state == ST_RUN) &&
                   (((mode_r == M_UP) && (&q_fb)) || ((mode_r == M_DOWN) && (~|q_fb)));
`else
  assign sat_hit = 1'b0;
`endif

  always_comb begin
    j_out = '0;
    k_out = '0;
    if ((state == ST_RUN) && !sat_hit) begin
      case (mode_r)
        M_LOAD: begin
          j_out = val_r;
          k_out = ~val_r;
        end
        M_UP: begin
          j_out = t_up;
          k_out = t_up;
        end
        M_DOWN: begin
          j_out = t_dn;
          k_out = t_dn;
        end
        default: begin
          j_out = '0;
          k_out = '1;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_r <= M_LOAD;
      val_r  <= '0;
      cnt_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_r <= mode;
            val_r  <= load_val;
            if ((mode == M_UP) || (mode == M_DOWN)) begin
              cnt_r <= steps;
              state <= (steps == '0) ? ST_DONE : ST_RUN;
            end else begin
              cnt_r <= STEP_W'(1);
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt_r <= cnt_r - STEP_W'(1);
          if (sat_hit || (cnt_r == STEP_W'(1))) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JK_CTRL_SAT_EN
  logic sat_r;

  // Sticky until the next accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_r <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      sat_r <= 1'b0;
    end else if (sat_hit) begin
      sat_r <= 1'b1;
    end
  end

  assign sat = sat_r;
`else
  assign sat = 1'b0;
`endif

endmodule
